// File: rtl/cbc_ctrl_pkg.sv
// cbc_ctrl_pkg: shared widths, FSM encoding and the block cipher round function
package cbc_ctrl_pkg;
    localparam int N_K = 64;
    localparam int N_B = 32;
    localparam int ENC_LAT = 2;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_REL = 2'd2, S_OUT = 2'd3} state_e;
    function automatic logic [N_B-1:0] enc_f(input logic [N_K-1:0] k, input logic [N_B-1:0] m);
        logic [N_B-1:0] x;
        x = m ^ k[N_B-1:0];
        x = {x[N_B-6:0], x[N_B-1:N_B-5]} + k[N_K-1-:N_B];
        return x ^ (x >> 7);
    endfunction
endpackage

// File: rtl/cbc_ctrl_if.sv
// cbc_ctrl_if: plaintext-in / ciphertext-out valid/ready stream pair
interface cbc_ctrl_if;
    import cbc_ctrl_pkg::*;
    logic           in_valid;
    logic           in_ready;
    logic [N_B-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N_B-1:0] out_data;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/cbc_ctrl_enc.sv
// cbc_ctrl_enc: encrypt_v2 engine, 4-phase req/ack with ENC_LAT+1 cycles per phase.
// It has no reset, so ack may still be high after the controller is reset.
module cbc_ctrl_enc
    import cbc_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           req,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    output logic           ack,
    output logic [N_B-1:0] c
);
    logic [1:0]     dly_q, dly_d;
    logic           ack_q, ack_d;
    logic [N_B-1:0] c_q, c_d;
    logic           pend, fire;

    assign pend = req != ack_q;
    assign fire = pend && dly_q == 2'(ENC_LAT);

    always_comb begin
        dly_d = (pend && !fire) ? dly_q + 2'd1 : 2'd0;
        ack_d = fire ? req : ack_q;
        c_d   = (fire && req) ? enc_f(k, m) : c_q;
    end

    always_ff @(posedge clk) begin
        dly_q <= dly_d;
        ack_q <= ack_d;
        c_q   <= c_d;
    end

    assign ack = ack_q;
    assign c   = c_q;
endmodule

// File: rtl/cbc_ctrl.sv
// cbc_ctrl: ECB/CBC block-mode front end driving the encrypt engine over req/ack
module cbc_ctrl
    import cbc_ctrl_pkg::*;
#(
    parameter int N_CNT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_K-1:0]   k,
    input  logic             cbc,
    input  logic [N_B-1:0]   iv,
    input  logic             iv_ld,
    cbc_ctrl_if.slave        s,
    output logic             busy,
    output logic [N_CNT-1:0] count
);
    state_e           state_q, state_d;
    logic [N_B-1:0]   chain_q, chain_d, m_q, m_d, c_q, c_d, od_q, od_d;
    logic [N_K-1:0]   k_q, k_d;
    logic [N_CNT-1:0] cnt_q, cnt_d;
    logic             req, ack, acc, idle, ld;
    logic [N_B-1:0]   c;

    cbc_ctrl_enc u_enc (.clk(clk), .req(req), .k(k_q), .m(m_q), .ack(ack), .c(c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = acc ? S_REQ : S_IDLE;
            S_REQ:   state_d = ack ? S_REL : S_REQ;
            S_REL:   state_d = !ack ? S_OUT : S_REL;
            S_OUT:   state_d = s.out_ready ? S_IDLE : S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idle       = state_q == S_IDLE;
        req        = state_q == S_REQ;
        s.out_valid = state_q == S_OUT;
        busy       = !idle;
        s.in_ready = idle && !iv_ld && !ack;
    end

    // iv_ld has priority over an accept, hence in_ready is masked by it above
    always_comb begin
        ld      = idle && iv_ld;
        acc     = s.in_valid && s.in_ready;
        m_d     = acc ? s.in_data ^ (cbc ? chain_q : '0) : m_q;
        k_d     = acc ? k : k_q;
        c_d     = (req && ack) ? c : c_q;
        od_d    = (state_q == S_REL && !ack) ? c_q : od_q;
        chain_d = ld ? iv : (state_q == S_REL && !ack) ? c_q : chain_q;
        cnt_d   = ld ? '0 : (s.out_valid && s.out_ready) ? cnt_q + N_CNT'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            m_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
            od_q    <= '0;
            cnt_q   <= '0;
        end else begin
            chain_q <= chain_d;
            m_q     <= m_d;
            k_q     <= k_d;
            c_q     <= c_d;
            od_q    <= od_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s.out_data = od_q;
    assign count      = cnt_q;
endmodule

// File: tb/tb_cbc_ctrl.sv
// tb_cbc_ctrl: scoreboard bench for cbc_ctrl; a second instance with N_CNT=2 shadows the first
module tb_cbc_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [63:0] k = '0;
    logic        cbc = 0;
    logic [31:0] iv = '0;
    logic        iv_ld = 0;
    logic        busy, busy2;
    logic [15:0] count;
    logic [1:0]  count2;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mchain = '0;
    logic [63:0] v0k;
    logic [31:0] v0m;

    cbc_ctrl_if s();
    cbc_ctrl_if s2();

    assign s2.in_valid  = s.in_valid;
    assign s2.in_data   = s.in_data;
    assign s2.out_ready = s.out_ready;

    cbc_ctrl #(.N_CNT(16)) dut (.clk(clk), .rst_n(rst_n), .k(k), .cbc(cbc), .iv(iv), .iv_ld(iv_ld),
                                .s(s), .busy(busy), .count(count));
    cbc_ctrl #(.N_CNT(2)) dut2 (.clk(clk), .rst_n(rst_n), .k(k), .cbc(cbc), .iv(iv), .iv_ld(iv_ld),
                                .s(s2), .busy(busy2), .count(count2));

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [63:0] kk, input logic [31:0] m);
        logic [31:0] t;
        t = m ^ kk[31:0];
        t = ((t << 5) | (t >> 27)) + kk[63:32];
        return t ^ (t >> 7);
    endfunction

    task automatic put(input logic [63:0] kk, input logic [31:0] d, input logic c);
        int t = 0;
        @(negedge clk);
        k = kk; cbc = c; s.in_data = d; s.in_valid = 1;
        while (!s.in_ready && t < 50) begin @(negedge clk); t++; end
        n_vec++;
        if (!s.in_ready) begin n_err++; $display("FAIL accept_timeout in_ready=%0b required 1", s.in_ready); end
        exp_q.push_back(model(kk, d ^ (c ? mchain : 32'd0)));
        @(negedge clk);
        s.in_valid = 0; k = {$urandom, $urandom}; s.in_data = $urandom; cbc = ~c;
    endtask

    task automatic get();
        int t = 0;
        logic [31:0] e;
        while (!s.out_valid && t < 50) begin @(negedge clk); t++; end
        n_vec++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (!s.out_valid || s.out_data !== e) begin
            n_err++; $display("FAIL out_data valid=%0b got=%h required=%h", s.out_valid, s.out_data, e);
        end
        mchain = e;
        s.out_ready = 1;
        @(negedge clk);
        s.out_ready = 0;
    endtask

    task automatic test_reset();
        s.in_valid = 0; s.in_data = '0; s.out_ready = 0;
        @(negedge clk);
        n_vec += 4;
        if (busy !== 0) begin n_err++; $display("FAIL reset_busy got=%0b required=0", busy); end
        if (s.out_valid !== 0) begin n_err++; $display("FAIL reset_out_valid got=%0b required=0", s.out_valid); end
        if (count !== 0) begin n_err++; $display("FAIL reset_count got=%0d required=0", count); end
        if (s.out_data !== 0) begin n_err++; $display("FAIL reset_out_data got=%h required=0", s.out_data); end
        rst_n = 1;
        @(negedge clk);
        n_vec++;
        if (s.in_ready !== 1) begin n_err++; $display("FAIL reset_in_ready got=%0b required=1", s.in_ready); end
    endtask

    task automatic test_ecb();
        for (int i = 0; i < 6; i++) begin
            logic [63:0] kk = {$urandom, $urandom};
            logic [31:0] d = $urandom;
            if (i == 0) begin v0k = kk; v0m = d; end
            put(kk, d, 0);
            get();
            n_vec++;
            if (count !== 16'(i + 1)) begin n_err++; $display("FAIL ecb_count got=%0d required=%0d", count, i + 1); end
        end
    endtask

    task automatic test_cbc();
        @(negedge clk); iv = $urandom; iv_ld = 1;
        @(negedge clk); iv_ld = 0; mchain = iv;
        n_vec += 2;
        if (count !== 0) begin n_err++; $display("FAIL cbc_ivld_count got=%0d required=0", count); end
        if (dut.chain_q !== iv) begin n_err++; $display("FAIL cbc_ivld_chain got=%h required=%h", dut.chain_q, iv); end
        for (int i = 0; i < 4; i++) begin
            put({$urandom, $urandom}, $urandom, 1);
            get();
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        logic [31:0] od;
        logic [15:0] c0 = count;
        put({$urandom, $urandom}, $urandom, 1);
        while (!s.out_valid && t < 50) begin @(negedge clk); t++; end
        od = s.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec += 4;
            if (s.out_valid !== 1) begin n_err++; $display("FAIL bp_valid got=%0b required=1", s.out_valid); end
            if (s.out_data !== od) begin n_err++; $display("FAIL bp_stable got=%h required=%h", s.out_data, od); end
            if (s.in_ready !== 0) begin n_err++; $display("FAIL bp_in_ready got=%0b required=0", s.in_ready); end
            if (busy !== 1) begin n_err++; $display("FAIL bp_busy got=%0b required=1", busy); end
        end
        get();
        n_vec += 3;
        if (count !== c0 + 16'd1) begin n_err++; $display("FAIL bp_count got=%0d required=%0d", count, c0 + 16'd1); end
        if (busy !== 0) begin n_err++; $display("FAIL bp_idle got=%0b required=0", busy); end
        if (s.out_valid !== 0) begin n_err++; $display("FAIL bp_valid_drop got=%0b required=0", s.out_valid); end
    endtask

    task automatic test_iv_ld();
        logic [15:0] c0;
        @(negedge clk); iv = $urandom; iv_ld = 1; s.in_valid = 1; s.in_data = $urandom;
        @(negedge clk);
        n_vec += 3;
        if (busy !== 0) begin n_err++; $display("FAIL ivld_accept busy=%0b required=0", busy); end
        if (dut.chain_q !== iv) begin n_err++; $display("FAIL ivld_chain got=%h required=%h", dut.chain_q, iv); end
        if (count !== 0) begin n_err++; $display("FAIL ivld_count got=%0d required=0", count); end
        iv_ld = 0; s.in_valid = 0; mchain = iv;
        put({$urandom, $urandom}, $urandom, 1);
        iv = ~iv; iv_ld = 1;
        get();
        c0 = count;
        n_vec += 2;
        if (dut.chain_q !== mchain) begin n_err++; $display("FAIL ivld_busy_chain got=%h required=%h", dut.chain_q, mchain); end
        if (c0 !== 16'd1) begin n_err++; $display("FAIL ivld_busy_count got=%0d required=1", c0); end
        iv_ld = 0;
        put({$urandom, $urandom}, $urandom, 1);
        get();
    endtask

    task automatic test_reset_mid();
        int t = 0;
        put({$urandom, $urandom}, $urandom, 0);
        while (dut.ack !== 1 && t < 50) begin @(negedge clk); t++; end
        rst_n = 0;
        #1;
        n_vec += 3;
        if (dut.req !== 0) begin n_err++; $display("FAIL rstmid_req got=%0b required=0", dut.req); end
        if (s.out_valid !== 0) begin n_err++; $display("FAIL rstmid_out_valid got=%0b required=0", s.out_valid); end
        if (busy !== 0) begin n_err++; $display("FAIL rstmid_busy got=%0b required=0", busy); end
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        mchain = '0;
        n_vec += 2;
        if (s.in_ready !== 0) begin n_err++; $display("FAIL rstmid_in_ready got=%0b required=0", s.in_ready); end
        if (count !== 0) begin n_err++; $display("FAIL rstmid_count got=%0d required=0", count); end
        put(v0k, v0m, 0);
        get();
        n_vec++;
        if (count !== 16'd1) begin n_err++; $display("FAIL rstmid_rerun_count got=%0d required=1", count); end
    endtask

    task automatic test_wrap();
        @(negedge clk); iv_ld = 1;
        @(negedge clk); iv_ld = 0; mchain = iv;
        for (int i = 0; i < 5; i++) begin
            put({$urandom, $urandom}, $urandom, 0);
            get();
            n_vec += 2;
            if (count2 !== 2'((i + 1) % 4)) begin n_err++; $display("FAIL wrap_count2 got=%0d required=%0d", count2, (i + 1) % 4); end
            if (count !== 16'(i + 1)) begin n_err++; $display("FAIL wrap_count16 got=%0d required=%0d", count, i + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_ecb();
        test_cbc();
        test_backpressure();
        test_iv_ld();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
